// File: rtl/vcm_i2c_pkg.sv
// Shared types and constants for the VCM driver I2C slave emulator.
package vcm_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned WR_WORD_BYTES = 2;
  localparam int unsigned PD_BIT        = 15;
  localparam int unsigned POS_MSB       = 13;
  localparam int unsigned POS_LSB       = 4;

  localparam logic [3:0] BIT_LAST   = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] BIT_ACK    = 4'(BITS_PER_BYTE);
  localparam logic [1:0] WR_SAT_CNT = 2'(WR_WORD_BYTES);

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection in the clk domain.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_high;

  // Reset to the idle-bus level so release never fabricates an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // SCL must be high in both samples, so a coincident SCL edge counts as data.
  assign scl_high  = scl_q[1] & scl_q[2];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_high & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_high & sda_q[1] & ~sda_q[2];
  assign sda_sync  = sda_q[1];

endmodule

// File: rtl/vcm_i2c_slave.sv
// I2C slave emulating the VCM focus driver: captures a 16-bit command word on
// writes and returns it on reads.
module vcm_i2c_slave
  import vcm_i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h0C,
  parameter logic [15:0] RESET_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] vcm_word,
  output logic [9:0]  vcm_pos,
  output logic        vcm_pd,
  output logic        word_valid,
  output logic        busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda_sync)
  );

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [15:0] word_q, word_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;

  assign rx_byte = {shift_q[6:0], sda_sync};
  assign rd_byte = byte_cnt_q[0] ? word_q[7:0] : word_q[15:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      shadow_q   <= '0;
      word_q     <= RESET_WORD;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;

    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // bit_cnt = BIT_ACK marks that the 9th rise has been seen, so the
        // next fall ends the ACK slot rather than starting it.
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = BIT_ACK;
            if (state_q == ST_WR_ACK) begin
              if (byte_cnt_q == 2'd0) begin
                shadow_d = shift_q;
              end else begin
                word_d  = {shadow_q, shift_q};
                valid_d = 1'b1;
              end
              if (byte_cnt_q != WR_SAT_CNT) byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q != BIT_ACK) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_RD_BYTE;
                tx_d     = rd_byte;
                sda_oe_d = ~rd_byte[7];
              end else begin
                state_d  = ST_WR_BYTE;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = (byte_cnt_q == WR_SAT_CNT) ? ST_WAIT_STOP : ST_WR_ACK;
            end
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == BIT_ACK) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_sync) begin
              bit_cnt_d  = BIT_ACK;
              byte_cnt_d = {1'b0, ~byte_cnt_q[0]};
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q == BIT_ACK) begin
            state_d   = ST_RD_BYTE;
            bit_cnt_d = '0;
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe     = sda_oe_q;
  assign vcm_word   = word_q;
  assign vcm_pos    = word_q[POS_MSB:POS_LSB];
  assign vcm_pd     = word_q[PD_BIT];
  assign word_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vcm_i2c_slave.sv
// Self-checking bench for vcm_i2c_slave: bit-banged I2C master, vector table,
// hand sequences for repeated START / read / reset, and randomized transactions.
module tb_vcm_i2c_slave;

  localparam logic [15:0] RST_WORD = 16'h0A5C;
  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, word_valid, busy, vcm_pd;
  logic [15:0] vcm_word;
  logic [9:0]  vcm_pos;

  assign sda_line = sda_m & ~sda_oe;

  vcm_i2c_slave #(.SLAVE_ADDR(7'h0C), .RESET_WORD(RST_WORD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .vcm_word   (vcm_word),
    .vcm_pos    (vcm_pos),
    .vcm_pd     (vcm_pd),
    .word_valid (word_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (word_valid) pulse_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  addr;
    int          n;
    logic [31:0] data;
    logic [4:0]  exp_ack;
    logic [15:0] exp_word;
    int          exp_pulses;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    s = sda_line;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  task automatic do_write(input logic [7:0] addr, input int n, input logic [31:0] data,
                          output logic [4:0] acks);
    logic a;
    logic [31:0] d;
    acks = '0;
    d = data;
    i2c_start;
    write_byte(addr, a);
    acks[4] = a;
    for (int i = 0; i < n; i++) begin
      write_byte(d[31:24], a);
      acks[3 - i] = a;
      d = d << 8;
    end
    i2c_stop;
    tick(4);
  endtask

  logic [15:0] exp_word;

  initial begin
    logic [4:0]  acks;
    logic [4:0]  exp_acks;
    logic [7:0]  rb;
    logic [7:0]  exp_b;
    logic        a;
    int          p0, b0;

    vecs[0] = '{8'h18, 2, 32'h1234_0000, 5'b11100, 16'h1234, 1, 1'b1};
    vecs[1] = '{8'h1A, 1, 32'h1A00_0000, 5'b00000, 16'h1234, 0, 1'b0};
    vecs[2] = '{8'h18, 3, 32'h1122_3300, 5'b11100, 16'h1122, 1, 1'b1};
    vecs[3] = '{8'h18, 1, 32'h5500_0000, 5'b11000, 16'h1122, 0, 1'b1};
    vecs[4] = '{8'h18, 4, 32'hDEAD_BEEF, 5'b11100, 16'hDEAD, 1, 1'b1};
    vecs[5] = '{8'h18, 2, 32'h1234_0000, 5'b11100, 16'h1234, 1, 1'b1};

    // Reset state
    tick(3);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_word", vcm_word, RST_WORD);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick(4);

    // Vector table of write transactions
    for (int k = 0; k < 6; k++) begin
      p0 = pulse_cnt;
      b0 = busy_cnt;
      do_write(vecs[k].addr, vecs[k].n, vecs[k].data, acks);
      chk($sformatf("v%0d_ack", k), acks, vecs[k].exp_ack);
      chk($sformatf("v%0d_word", k), vcm_word, vecs[k].exp_word);
      chk($sformatf("v%0d_pos", k), vcm_pos, vecs[k].exp_word[13:4]);
      chk($sformatf("v%0d_pd", k), vcm_pd, vecs[k].exp_word[15]);
      chk($sformatf("v%0d_pulses", k), pulse_cnt - p0, vecs[k].exp_pulses);
      chk($sformatf("v%0d_busy_seen", k), busy_cnt != b0, vecs[k].exp_busy);
      chk($sformatf("v%0d_busy_end", k), busy, 1'b0);
    end
    exp_word = 16'h1234;

    // Repeated START discards the partial write
    p0 = pulse_cnt;
    acks = '0;
    i2c_start;
    write_byte(8'h18, a); acks[4] = a;
    write_byte(8'hAB, a); acks[3] = a;
    i2c_start;
    write_byte(8'h18, a); acks[2] = a;
    write_byte(8'h80, a); acks[1] = a;
    write_byte(8'h05, a); acks[0] = a;
    i2c_stop;
    tick(4);
    chk("rs_ack", acks, 5'b11111);
    chk("rs_word", vcm_word, 16'h8005);
    chk("rs_pd", vcm_pd, 1'b1);
    chk("rs_pos", vcm_pos, 10'h000);
    chk("rs_pulses", pulse_cnt - p0, 1);

    // Read back 0x1234 with ACK, ACK, NACK
    do_write(8'h18, 2, 32'h1234_0000, acks);
    chk("rd_setup_ack", acks, 5'b11100);
    exp_word = 16'h1234;
    i2c_start;
    write_byte(8'h19, a);
    chk("rd_addr_ack", a, 1'b1);
    read_byte(1'b1, rb); chk("rd_b0", rb, 8'h12);
    read_byte(1'b1, rb); chk("rd_b1", rb, 8'h34);
    read_byte(1'b0, rb); chk("rd_b2", rb, 8'h12);
    chk("rd_nack_release", sda_oe, 1'b0);
    i2c_stop;
    tick(4);
    chk("rd_end_oe", sda_oe, 1'b0);
    chk("rd_end_busy", busy, 1'b0);
    chk("rd_word_kept", vcm_word, 16'h1234);

    // ACK latency and asynchronous reset inside the ACK slot
    i2c_start;
    for (int i = 7; i >= 1; i--) begin
      logic [7:0] ab;
      ab = 8'h18;
      clock_bit(ab[i], a);
    end
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(2 * Q);
    scl = 1'b0;
    tick(2);
    chk("ack_lat_early", sda_oe, 1'b0);
    tick(1);
    chk("ack_lat", sda_oe, 1'b1);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_oe", sda_oe, 1'b0);
    chk("mid_rst_word", vcm_word, RST_WORD);
    chk("mid_rst_busy", busy, 1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    scl = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
    chk("post_rst_idle_oe", sda_oe, 1'b0);
    i2c_stop;
    tick(4);
    p0 = pulse_cnt;
    do_write(8'h18, 2, 32'hABCD_0000, acks);
    chk("post_rst_ack", acks, 5'b11100);
    chk("post_rst_word", vcm_word, 16'hABCD);
    chk("post_rst_pulses", pulse_cnt - p0, 1);
    exp_word = 16'hABCD;

    // Randomized transactions against a transaction-level model
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = $urandom_range(1, 4);
        i2c_start;
        write_byte(8'h19, a);
        chk($sformatf("r%0d_rd_addr_ack", t), a, 1'b1);
        for (int i = 0; i < n; i++) begin
          exp_b = (i % 2 == 0) ? exp_word[15:8] : exp_word[7:0];
          read_byte(i != n - 1, rb);
          chk($sformatf("r%0d_rd_b%0d", t, i), rb, exp_b);
        end
        i2c_stop;
        tick(4);
        chk($sformatf("r%0d_rd_word", t), vcm_word, exp_word);
      end else begin
        logic        match;
        logic [6:0]  a7;
        logic [31:0] data;
        int          n;
        match = ($urandom_range(0, 3) != 0);
        a7 = match ? 7'h0C : 7'($urandom_range(0, 127));
        if (!match && a7 == 7'h0C) a7 = 7'h0D;
        n = $urandom_range(0, 4);
        data = $urandom;
        exp_acks = '0;
        exp_acks[4] = match;
        for (int i = 0; i < n; i++) exp_acks[3 - i] = match && (i < 2);
        p0 = pulse_cnt;
        do_write({a7, 1'b0}, n, data, acks);
        if (match && n >= 2) exp_word = data[31:16];
        chk($sformatf("r%0d_wr_ack", t), acks, exp_acks);
        chk($sformatf("r%0d_wr_word", t), vcm_word, exp_word);
        chk($sformatf("r%0d_wr_pos", t), vcm_pos, exp_word[13:4]);
        chk($sformatf("r%0d_wr_pd", t), vcm_pd, exp_word[15]);
        chk($sformatf("r%0d_wr_pulses", t), pulse_cnt - p0, (match && n >= 2) ? 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcm_i2c_slave.md
# vcm_i2c_slave

I2C slave responder that emulates the voice-coil-motor (VCM) driver on the camera focus bus. It samples SCL/SDA in the `clk` domain, ACKs writes to its 7-bit address and captures the 16-bit VCM command word (power-down bit plus 10-bit DAC position). It returns that word on reads. It sits at the far end of the auto-focus I2C master, so focus sweeps can run in emulation and on-board loopback without the physical lens module.

## Interface
Parameters:
- `SLAVE_ADDR`, default 7'h0C: 7-bit I2C address matched.
- `RESET_WORD`, default 16'h0000: value of the command register after reset.

Ports:
- `clk`, in, 1: sole clock; must be ≥ 10× SCL rate.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `scl_i`, in, 1: SCL line level, asynchronous.
- `sda_i`, in, 1: SDA line level, asynchronous.
- `sda_oe`, out, 1: 1 pulls SDA low (open drain); the top level ties the pad as `sda_oe ? 0 : 'z`.
- `vcm_word`, out, 16: last complete command word, {PD, FLAG, D[9:0], S[3:0]}.
- `vcm_pos`, out, 10: equals `vcm_word[13:4]`.
- `vcm_pd`, out, 1: equals `vcm_word[15]`.
- `word_valid`, out, 1: one-cycle pulse when `vcm_word` updates.
- `busy`, out, 1: high from an address-matched START until the next STOP or START.

## Operation
- Input conditioning:
  - 2-flop synchronizer on each line, plus a third register for edge detection.
  - START is SDA falling while SCL high; STOP is SDA rising while SCL high.
  - Bits are sampled on SCL rising edges.
  - SDA is changed only on SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- START in any state goes to ADDR and clears the bit and byte counters. A repeated START discards any partial write.
- STOP in any state goes to IDLE and releases `sda_oe`.
- ADDR:
  - Shift 8 bits MSB first.
  - If [7:1] == `SLAVE_ADDR`: go to ADDR_ACK with the R/W bit latched.
  - Otherwise go to WAIT_STOP with no ACK.
- ADDR_ACK:
  - Assert `sda_oe` from the 8th SCL falling edge to the 9th SCL falling edge.
  - Then go to WR_BYTE (W = 0) or RD_BYTE (R = 1).
- WR_BYTE / WR_ACK:
  - Byte 0 goes to a shadow high byte and is ACKed.
  - Byte 1 is ACKed. `vcm_word` ← {shadow, byte1} and `word_valid` pulses on the cycle the 9th SCL rising edge is detected.
  - Bytes 2 and later are NACKed (SDA released), ignored, and the state goes to WAIT_STOP.
  - A write of 1 data byte followed by STOP leaves `vcm_word` unchanged.
- RD_BYTE / RD_ACK:
  - Drive the data bit on each SCL falling edge: `sda_oe` = ~bit, MSB first.
  - The byte sequence is `vcm_word[15:8]`, then `[7:0]`, then it wraps.
  - Release SDA during the master's ACK slot and sample it on the 9th SCL rise.
  - Master ACK: next byte. Master NACK: WAIT_STOP.
- WAIT_STOP: the block is passive; only START or STOP exits.

## Timing
- Reset values:
  - `sda_oe` = 0, `vcm_word` = `RESET_WORD`, `word_valid` = 0, `busy` = 0.
  - State = IDLE; counters = 0.
- Detection latency: 3 `clk` from a pin edge to internal action. This provides SDA hold after SCL fall.
- `sda_oe` changes 3 `clk` after the SCL falling edge at the pin.
- `vcm_word`, `vcm_pos`, `vcm_pd` update together. `vcm_pos` and `vcm_pd` are combinational slices with no extra latency.
- Simultaneous START and STOP cannot occur (mutually exclusive SDA edges). If the SCL and SDA edges are detected in the same cycle, treat it as a data change, not START/STOP.
- Reset mid-transaction: `sda_oe` drops immediately (asynchronous). After release, the block ignores the bus until the next START.
- The bit counter is 4 bits (0..8). The byte counter saturates at 2 for writes and wraps modulo 2 for reads.

## Structure
- Package `vcm_i2c_pkg`:
  - State enum.
  - `BITS_PER_BYTE` = 8.
  - `WR_WORD_BYTES` = 2.
  - Field positions `PD_BIT` = 15, `POS_MSB` = 13, `POS_LSB` = 4.
- Sub-module `i2c_line_sync`:
  - Synchronizers.
  - Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and synced SDA.
- The FSM, shift registers and command register live in `vcm_i2c_slave`.

## Test plan
- Write 0x18, 0x12, 0x34 → ACK on all three 9th clocks; `vcm_word` = 16'h1234, `vcm_pos` = 10'h123, `vcm_pd` = 0; exactly one `word_valid` pulse.
- Write to address 0x0D (byte 0x1A) → `sda_oe` never asserted; `vcm_word` unchanged; `busy` stays 0.
- Write 0x18, 0xAB, repeated START, then write 0x18, 0x80, 0x05 → first write discarded; `vcm_word` = 16'h8005, `vcm_pd` = 1.
- After the word is 16'h1234: read 0x19, master ACK, ACK, NACK → bytes returned 0x12, 0x34, 0x12; SDA released after the NACK.
- Write 0x18, 0x11, 0x22, 0x33 → third data byte NACKed; `vcm_word` = 16'h1122.
- Assert `reset_n` low during an ACK slot → `sda_oe` = 0 within the same cycle; `vcm_word` = `RESET_WORD`; next transaction completes normally.
